compute_clock_gate_controller: RTL and testbench



---
 rtl/compute_clock_gate_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_compute_clock_gate_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/compute_clock_gate_controller.sv
// compute_clock_gate_controller: sequences the active-low enable of the gated
// compute clock. It runs a programmed cycle budget, drains the gating buffer
// before declaring the clock stopped, and hands the frozen core array to stall
// requesters in round-robin order.
// Optional build macro: CLOCK_GATE_STATS_EN adds the stall_cycles output.
module compute_clock_gate_controller #(
    parameter int NUM_REQ      = 4,
    parameter int COUNT_W      = 48,
    parameter int GATE_LATENCY = 2
) (
    input  logic               control_clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] cycle_budget,
    input  logic               abort,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               compute_clock_en_n,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] cycles_executed
`ifdef CLOCK_GATE_STATS_EN
    ,
    output logic [COUNT_W-1:0] stall_cycles
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAT_W = $clog2(GATE_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_GRANT} state_t;
    typedef enum logic [1:0] {R_FINISH, R_ABORT, R_STALL} reason_t;

    state_t             state_q, state_d;
    reason_t            reason_q, reason_d;
    logic [LAT_W-1:0]   drain_q, drain_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [COUNT_W-1:0] cyc_q, cyc_d;
    logic               en_n_q, en_n_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               gap_q, gap_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [PTR_W-1:0]   pick;
`ifdef CLOCK_GATE_STATS_EN
    logic [COUNT_W-1:0] stall_q, stall_d;
`endif

    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] c);
        return (c == PTR_W'(NUM_REQ - 1)) ? '0 : c + 1'b1;
    endfunction

    // First requester at or after the pointer, wrapping modulo NUM_REQ.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [PTR_W-1:0]   p);
        logic [PTR_W-1:0] c;
        logic [PTR_W-1:0] sel;
        logic             found;
        c     = p;
        sel   = p;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && r[c]) begin
                sel   = c;
                found = 1'b1;
            end
            c = rr_next(c);
        end
        return sel;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] g;
        g      = '0;
        g[idx] = 1'b1;
        return g;
    endfunction

    // Next-state and registered-output logic for the run/drain/grant sequencer.
    always_comb begin
        state_d  = state_q;
        reason_d = reason_q;
        drain_d  = drain_q;
        rem_d    = rem_q;
        cyc_d    = cyc_q;
        en_n_d   = en_n_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        ptr_d    = ptr_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        pick     = rr_pick(req, ptr_q);
`ifdef CLOCK_GATE_STATS_EN
        stall_d  = stall_q;
        if ((state_q == S_DRAIN && reason_q == R_STALL) || state_q == S_GRANT)
            stall_d = stall_q + 1'b1;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef CLOCK_GATE_STATS_EN
                    stall_d = '0;
`endif
                    if (cycle_budget != '0) begin
                        rem_d   = cycle_budget;
                        cyc_d   = '0;
                        en_n_d  = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // This cycle ran with the clock enabled, so it always counts.
                rem_d = rem_q - 1'b1;
                cyc_d = cyc_q + 1'b1;
                if (abort || rem_q == COUNT_W'(1) || req != '0) begin
                    en_n_d   = 1'b1;
                    drain_d  = '0;
                    state_d  = S_DRAIN;
                    reason_d = abort ? R_ABORT :
                               (rem_q == COUNT_W'(1)) ? R_FINISH : R_STALL;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (abort) reason_d = R_ABORT;
                if (drain_q == LAT_W'(GATE_LATENCY - 1)) begin
                    if (abort || reason_q != R_STALL) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (req != '0) begin
                        grant_d = onehot(pick);
                        gidx_d  = pick;
                        gap_d   = 1'b0;
                        state_d = S_GRANT;
                    end else begin
                        en_n_d  = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end
            S_GRANT: begin
                if (abort) reason_d = R_ABORT;
                if (!gap_q) begin
                    // An active grant is only ever ended by its own requester.
                    if (!req[gidx_q]) begin
                        grant_d = '0;
                        ptr_d   = rr_next(gidx_q);
                        gap_d   = 1'b1;
                    end
                end else if (abort || reason_q == R_ABORT) begin
                    gap_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (req != '0) begin
                    grant_d = onehot(pick);
                    gidx_d  = pick;
                    gap_d   = 1'b0;
                end else begin
                    gap_d   = 1'b0;
                    en_n_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset gates the clock off at once.
    always_ff @(posedge control_clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            reason_q <= R_FINISH;
            drain_q  <= '0;
            rem_q    <= '0;
            cyc_q    <= '0;
            en_n_q   <= 1'b1;
            grant_q  <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            gap_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef CLOCK_GATE_STATS_EN
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            reason_q <= reason_d;
            drain_q  <= drain_d;
            rem_q    <= rem_d;
            cyc_q    <= cyc_d;
            en_n_q   <= en_n_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            gap_q    <= gap_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef CLOCK_GATE_STATS_EN
            stall_q  <= stall_d;
`endif
        end
    end

    assign grant              = grant_q;
    assign compute_clock_en_n = en_n_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign cycles_executed    = cyc_q;
`ifdef CLOCK_GATE_STATS_EN
    assign stall_cycles       = stall_q;
`endif

endmodule

// File: tb/tb_compute_clock_gate_controller.sv
// Directed bench for compute_clock_gate_controller (default parameters).
module tb_compute_clock_gate_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [47:0] budget = '0;
    logic        abort = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  grant;
    logic        en_n;
    logic        busy;
    logic        done;
    logic [47:0] cycles;
`ifdef CLOCK_GATE_STATS_EN
    logic [47:0] stall_cycles;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    compute_clock_gate_controller dut (
        .control_clock      (clk),
        .reset_n            (reset_n),
        .start              (start),
        .cycle_budget       (budget),
        .abort              (abort),
        .req                (req),
        .grant              (grant),
        .compute_clock_en_n (en_n),
        .busy               (busy),
        .done               (done),
        .cycles_executed    (cycles)
`ifdef CLOCK_GATE_STATS_EN
        ,
        .stall_cycles       (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic pulse_start(input logic [47:0] b);
        start  = 1'b1;
        budget = b;
        tick();
        start  = 1'b0;
    endtask

    // Run until done with a bound; lo counts samples with the clock enabled.
    task automatic wait_done(input int bound, output int lo);
        lo = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (en_n == 1'b0) lo++;
            if (done) break;
        end
        chk("wait_done", done, 1);
    endtask

    int lo;

    initial begin
        // Reset state
        do_reset();
        chk("rst_en_n", en_n, 1);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cycles", cycles, 0);

        // Budget 5, no requests
        pulse_start(48'd5);
        chk("b5_en_n_start", en_n, 0);
        chk("b5_busy", busy, 1);
        lo = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (en_n) break;
            lo++;
        end
        chk("b5_low_cycles", lo, 5);
        chk("b5_cycles", cycles, 5);
        chk("b5_done_early0", done, 0);
        tick();
        chk("b5_done_early1", done, 0);
        chk("b5_busy_drain", busy, 1);
        tick();
        chk("b5_done", done, 1);
        chk("b5_busy_end", busy, 0);
        tick();
        chk("b5_done_single", done, 0);

        // Zero budget
        pulse_start(48'd0);
        chk("b0_done", done, 1);
        chk("b0_en_n", en_n, 1);
        chk("b0_busy", busy, 0);
        tick();
        chk("b0_done_single", done, 0);

        // Budget 100 with a stall from req[2]
        pulse_start(48'd100);
        for (int i = 0; i < 9; i++) tick();
        req = 4'b0100;
        tick();
        chk("st_en_n_off", en_n, 1);
        chk("st_cycles10", cycles, 10);
        tick();
        chk("st_drain_grant0", grant, 0);
        tick();
        chk("st_grant", grant, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_grant_hold", grant, 4'b0100);
        end
        req = 4'b0000;
        tick();
        chk("st_gap_grant", grant, 0);
        chk("st_gap_en_n", en_n, 1);
        tick();
        chk("st_resume", en_n, 0);
        wait_done(300, lo);
        chk("st_resume_low", lo, 89);
        chk("st_cycles100", cycles, 100);

        // Round-robin over 0b1011 from pointer 0
        do_reset();
        pulse_start(48'd50);
        for (int i = 0; i < 3; i++) tick();
        req = 4'b1011;
        tick();
        chk("rr_en_n_off", en_n, 1);
        tick();
        chk("rr_drain", grant, 0);
        tick();
        chk("rr_g0", grant, 4'b0001);
        req = 4'b1010;
        tick();
        chk("rr_gap0", grant, 0);
        chk("rr_gap0_en_n", en_n, 1);
        tick();
        chk("rr_g1", grant, 4'b0010);
        req = 4'b1000;
        tick();
        chk("rr_gap1", grant, 0);
        tick();
        chk("rr_g3", grant, 4'b1000);
        chk("rr_g3_en_n", en_n, 1);
        req = 4'b0000;
        tick();
        chk("rr_gap3", grant, 0);
        chk("rr_gap3_en_n", en_n, 1);
        tick();
        chk("rr_resume", en_n, 0);
        wait_done(200, lo);
        chk("rr_cycles50", cycles, 50);

        // Abort mid-run
        pulse_start(48'd1000);
        for (int i = 0; i < 20; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_en_n", en_n, 1);
        chk("ab_cycles", cycles, 21);
        tick();
        chk("ab_done_early", done, 0);
        tick();
        chk("ab_done", done, 1);
        chk("ab_busy", busy, 0);
        chk("ab_cycles_end", cycles, 21);

        // Abort during grant
        pulse_start(48'd1000);
        for (int i = 0; i < 3; i++) tick();
        req = 4'b0001;
        tick();
        tick();
        tick();
        chk("abg_grant", grant, 4'b0001);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abg_grant_held", grant, 4'b0001);
        tick();
        chk("abg_grant_held2", grant, 4'b0001);
        chk("abg_no_done", done, 0);
        req = 4'b0000;
        tick();
        chk("abg_gap_grant", grant, 0);
        chk("abg_gap_done", done, 0);
        tick();
        chk("abg_done", done, 1);
        chk("abg_busy", busy, 0);
        chk("abg_en_n", en_n, 1);

        // Reset during grant
        pulse_start(48'd1000);
        tick();
        tick();
        req = 4'b0010;
        tick();
        tick();
        tick();
        chk("rg_grant", grant, 4'b0010);
`ifdef CLOCK_GATE_STATS_EN
        chk("rg_stall_pre", stall_cycles, 2);
`endif
        reset_n = 1'b0;
        tick();
        chk("rg_grant0", grant, 0);
        chk("rg_en_n", en_n, 1);
        chk("rg_busy", busy, 0);
        chk("rg_done", done, 0);
`ifdef CLOCK_GATE_STATS_EN
        chk("rg_stall0", stall_cycles, 0);
`endif
        reset_n = 1'b1;
        req = 4'b0000;
        tick();
        chk("rg_no_done", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
